pc_stack: RTL and testbench

Parametrised program-counter sequencer for the processor unit, replacing the plain PC register. It adds a hardware call/return stack, a stall input for multi-cycle memory, and sticky halt/error status. The instruction decoder drives it; its `pca` output addresses instruction memory and feeds the ALU A-side select for PC-relative operations.

---
 rtl/pc_stack_if.sv | 29 ++
 rtl/pc_stack.sv | 127 ++++++++++++
 tb/tb_pc_stack.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_stack_if.sv
// Decoder <-> PC sequencer bundle: request strobes and jump target in,
// current PC, stack depth and sticky status out.
interface pc_stack_if #(
    parameter int PCW   = 8,
    parameter int DEPTH = 4
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic           h;
    logic           stall;
    logic           pcwe;
    logic           call;
    logic           ret;
    logic [PCW-1:0] npc;
    logic [PCW-1:0] pca;
    logic [SPW-1:0] sp;
    logic           halted;
    logic [1:0]     err;

    modport master (
        output h, stall, pcwe, call, ret, npc,
        input  pca, sp, halted, err
    );

    modport slave (
        input  h, stall, pcwe, call, ret, npc,
        output pca, sp, halted, err
    );
endinterface

// File: rtl/pc_stack.sv
// Program-counter sequencer with hardware call/return stack, stall and sticky halt.
// Optional macro PCSTK_CHECK_EN: stack over/underflow halts and sets err instead of wrapping.
module pc_stack #(
    parameter int             PCW   = 8,
    parameter int             DEPTH = 4,
    parameter logic [PCW-1:0] RSTPC = '0
) (
    input  logic      clk,
    input  logic      rst,
    pc_stack_if.slave bus
);

    localparam int             SPW     = $clog2(DEPTH + 1);
    localparam int             AW      = $clog2(DEPTH);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t         state_p0, state_n;
    logic [PCW-1:0] pc_p0, pc_n;
    logic [SPW-1:0] sp_p0, sp_n;
    logic [1:0]     err_p0, err_n;
    logic [PCW-1:0] stk_p0 [DEPTH];

    logic           push_we;
    logic           push_shift;
    logic [AW-1:0]  push_idx;
    logic [AW-1:0]  top_idx;
    logic [PCW-1:0] push_data;

    function automatic logic [PCW-1:0] pc_inc(input logic [PCW-1:0] pc);
        return pc + PCW'(1);
    endfunction

    // Saturating stack-pointer step, clamped to 0 .. DEPTH.
    function automatic logic [SPW-1:0] sp_step(input logic [SPW-1:0] s, input logic up);
        if (up)
            return (s == SP_FULL) ? s : s + SPW'(1);
        else
            return (s == '0) ? s : s - SPW'(1);
    endfunction

    assign top_idx   = AW'(sp_p0 - SPW'(1));
    assign push_idx  = AW'(sp_p0);
    assign push_data = pc_inc(pc_p0);

    // ---- stage p0: next-state decision ----
    always_comb begin
        state_n    = state_p0;
        pc_n       = pc_p0;
        sp_n       = sp_p0;
        err_n      = err_p0;
        push_we    = 1'b0;
        push_shift = 1'b0;

        if (state_p0 == S_RUN && !bus.stall) begin
            if (bus.h) begin
                state_n = S_HALT;
            end else if (bus.ret) begin
                if (sp_p0 != '0) begin
                    pc_n = stk_p0[top_idx];
                    sp_n = sp_step(sp_p0, 1'b0);
                end else begin
`ifdef PCSTK_CHECK_EN
                    err_n[1] = 1'b1;
                    state_n  = S_HALT;
`else
                    pc_n = stk_p0[DEPTH-1];
`endif
                end
            end else if (bus.call) begin
                if (sp_p0 < SP_FULL) begin
                    push_we = 1'b1;
                    sp_n    = sp_step(sp_p0, 1'b1);
                    pc_n    = bus.npc;
                end else begin
`ifdef PCSTK_CHECK_EN
                    err_n[0] = 1'b1;
                    state_n  = S_HALT;
`else
                    // Full circular stack: drop the oldest entry, newest lands on top.
                    push_we    = 1'b1;
                    push_shift = 1'b1;
                    pc_n       = bus.npc;
`endif
                end
            end else if (bus.pcwe) begin
                pc_n = bus.npc;
            end else begin
                pc_n = pc_inc(pc_p0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p0 <= S_RUN;
            pc_p0    <= RSTPC;
            sp_p0    <= '0;
            err_p0   <= 2'b00;
        end else begin
            state_p0 <= state_n;
            pc_p0    <= pc_n;
            sp_p0    <= sp_n;
            err_p0   <= err_n;
        end
    end

    // Stack storage carries no reset; its contents are only meaningful below sp.
    always_ff @(posedge clk) begin
        if (push_we) begin
            if (push_shift) begin
                for (int i = 0; i < DEPTH - 1; i++)
                    stk_p0[i] <= stk_p0[i+1];
                stk_p0[DEPTH-1] <= push_data;
            end else begin
                stk_p0[push_idx] <= push_data;
            end
        end
    end

    assign bus.pca    = pc_p0;
    assign bus.sp     = sp_p0;
    assign bus.halted = (state_p0 == S_HALT);
    assign bus.err    = err_p0;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_pc_stack;

    localparam int PCW   = 8;
    localparam int DEPTH = 4;
    localparam int MODN  = 1 << PCW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pc_stack_if #(.PCW(PCW), .DEPTH(DEPTH)) bus ();

    pc_stack #(.PCW(PCW), .DEPTH(DEPTH), .RSTPC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: PC, stack as a queue (back = top), sticky status.
    int       m_pc;
    int       m_q[$];
    int       m_slot_last;
    bit       m_halt;
    bit [1:0] m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pca"},    32'(bus.pca),    32'(m_pc));
        check({tag, ".sp"},     32'(bus.sp),     32'(m_q.size()));
        check({tag, ".halted"}, 32'(bus.halted), 32'(m_halt));
        check({tag, ".err"},    32'(bus.err),    32'(m_err));
    endtask

    task automatic model_reset();
        m_pc        = 0;
        m_q.delete();
        m_slot_last = 0;
        m_halt      = 1'b0;
        m_err       = 2'b00;
    endtask

    task automatic model_push(input int addr);
        m_q.push_back(addr);
        // The entry that lands in the deepest slot is what an unchecked underflow returns.
        if (m_q.size() == DEPTH) m_slot_last = addr;
    endtask

    task automatic model_edge(input bit ih, input bit ist, input bit ipw,
                              input bit icall, input bit iret, input int inpc);
        if (m_halt || ist) return;
        if (ih) begin
            m_halt = 1'b1;
        end else if (iret) begin
            if (m_q.size() > 0) begin
                m_pc = m_q.pop_back();
            end else begin
`ifdef PCSTK_CHECK_EN
                m_err[1] = 1'b1;
                m_halt   = 1'b1;
`else
                m_pc = m_slot_last;
`endif
            end
        end else if (icall) begin
            if (m_q.size() < DEPTH) begin
                model_push((m_pc + 1) % MODN);
                m_pc = inpc;
            end else begin
`ifdef PCSTK_CHECK_EN
                m_err[0] = 1'b1;
                m_halt   = 1'b1;
`else
                void'(m_q.pop_front());
                model_push((m_pc + 1) % MODN);
                m_pc = inpc;
`endif
            end
        end else if (ipw) begin
            m_pc = inpc;
        end else begin
            m_pc = (m_pc + 1) % MODN;
        end
    endtask

    task automatic step(input string tag, input bit ih, input bit ist, input bit ipw,
                        input bit icall, input bit iret, input int inpc);
        bus.h     = ih;
        bus.stall = ist;
        bus.pcwe  = ipw;
        bus.call  = icall;
        bus.ret   = iret;
        bus.npc   = PCW'(inpc);
        @(posedge clk);
        model_edge(ih, ist, ipw, icall, iret, inpc);
        #1;
        check_all(tag);
        bus.h = 1'b0; bus.stall = 1'b0; bus.pcwe = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Asynchronous reset between edges; released on the next falling edge.
    task automatic reset_mid(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.h = 1'b0; bus.stall = 1'b0; bus.pcwe = 1'b0;
        bus.call = 1'b0; bus.ret = 1'b0; bus.npc = '0;
        model_reset();

        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Free-running increment from RSTPC
        for (int i = 1; i <= 5; i++) begin
            idle("inc");
            check("inc.const", 32'(bus.pca), 32'(i));
        end
        for (int i = 0; i < 11; i++) idle("to10");
        check("at10", 32'(bus.pca), 32'h10);

        // Call / return
        step("call40", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 'h40);
        check("call40.const", 32'(bus.pca), 32'h40);
        idle("in41");
        idle("in42");
        check("in42.const", 32'(bus.pca), 32'h42);
        step("ret11", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("ret11.pca", 32'(bus.pca), 32'h11);
        check("ret11.sp",  32'(bus.sp),  32'h0);

        // Wrap at the top of the address space
        step("jfe", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 'hFE);
        idle("ff");
        idle("wrap");
        check("wrap.const", 32'(bus.pca), 32'h00);
        step("jff", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 'hFF);
        step("callff", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 'h30);
        step("retwrap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("retwrap.const", 32'(bus.pca), 32'h00);

        // Stall freezes everything while requests toggle
        step("call50", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 'h50);
        step("stall1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 'h77);
        step("stall2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 'h77);
        step("stall3", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 'h77);
        check("stall.pca", 32'(bus.pca), 32'h50);
        idle("unstall");
        check("unstall.const", 32'(bus.pca), 32'h51);
        step("ret01", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("ret01.const", 32'(bus.pca), 32'h01);

        // Simultaneous requests
        step("callpcwe", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 'h60);
        check("callpcwe.sp", 32'(bus.sp), 32'h1);
        step("retcall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 'h70);
        check("retcall.pca", 32'(bus.pca), 32'h02);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit rh, rs, rp, rc, rr;
            rh = ($urandom_range(0, 99) < 2);
            rs = ($urandom_range(0, 3) == 0);
            rp = ($urandom_range(0, 3) == 0);
            rc = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 3) == 0);
            if (rr && m_q.size() == 0) rr = 1'b0;
            step("rand", rh, rs, rp, rc, rr, int'($urandom_range(0, MODN - 1)));
            if (m_halt) begin
                idle("rand.hold");
                idle("rand.hold");
                reset_mid("rand.rst");
            end
        end

        // Overflow / underflow
        reset_mid("ovf.rst");
        step("c1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 'h10);
        step("c2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 'h20);
        step("c3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 'h30);
        step("c4", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 'h40);
        step("c5", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 'h50);
`ifdef PCSTK_CHECK_EN
        check("ovf.err",    32'(bus.err),    32'h1);
        check("ovf.halted", 32'(bus.halted), 32'h1);
        check("ovf.pca",    32'(bus.pca),    32'h40);
        reset_mid("unf.rst");
        step("unf", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("unf.err",    32'(bus.err),    32'h2);
        check("unf.halted", 32'(bus.halted), 32'h1);
        reset_mid("unf.clr");
`else
        check("ovf.sp",  32'(bus.sp),  32'h4);
        check("ovf.err", 32'(bus.err), 32'h0);
        for (int i = 0; i < 4; i++)
            step("ovf.ret", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("ovf.lastret", 32'(bus.pca), 32'h11);
        step("unf", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("unf.pca", 32'(bus.pca), 32'h41);
        check("unf.sp",  32'(bus.sp),  32'h0);
`endif

        // Halt, then async reset while halted
        step("j22", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 'h22);
        step("halt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            step("halt.hold", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 'h99);
            check("halt.pca", 32'(bus.pca), 32'h22);
        end
        reset_mid("halt.rst");
        check("halt.rst.halted", 32'(bus.halted), 32'h0);
        idle("post");
        check("post.const", 32'(bus.pca), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
